// File: rtl/dot_product_accumulator.sv
// ---------------------------------------------------------------------------
// dot_product_accumulator
//
// Purpose:
//   This block sits after the unsigned array multiplier. It accepts a stream
//   of 2*Width-bit products over a valid/ready handshake and adds up a
//   programmed number of them (the vector length). The unsigned dot-product
//   result is then offered on a second valid/ready handshake.
//
// Ports:
//   clk_i           clock, rising edge
//   rst_i           asynchronous reset, active-high
//   start_i         starts a new accumulation (only sampled in IDLE)
//   len_i           number of products to sum, sampled together with start_i
//   abort_i         synchronous abort; returns the block to IDLE from any state
//   prod_valid_i    product beat valid
//   prod_ready_o    the block accepts a product this cycle
//   prod_i          unsigned product from the multiplier
//   result_valid_o  dot-product result valid
//   result_ready_i  the consumer accepts the result
//   result_o        unsigned dot-product result
//   busy_o          high while accumulating or holding a result
//
// All outputs are decoded from registered state only, so there is no
// combinational path from any input to any output.
// ---------------------------------------------------------------------------
module dot_product_accumulator #(
  parameter int Width    = 8,
  parameter int LenWidth = 8,
  // Derived value; do not override. The largest possible sum,
  // (2^W-1)^2 * (2^L-1), fits in this width, so the accumulator cannot wrap.
  parameter int AccWidth = 2*Width+LenWidth
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [LenWidth-1:0]   len_i,
  input  logic                  abort_i,
  input  logic                  prod_valid_i,
  output logic                  prod_ready_o,
  input  logic [2*Width-1:0]    prod_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [AccWidth-1:0]   result_o,
  output logic                  busy_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [AccWidth-1:0] acc_q, acc_d;
  logic [LenWidth-1:0] remaining_q, remaining_d;

  // Zero-extended product, lined up with the accumulator width.
  logic [AccWidth-1:0] prod_ext;
  assign prod_ext = {{(AccWidth-2*Width){1'b0}}, prod_i};

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    remaining_d = remaining_q;
    if (abort_i) begin
      // Abort wins over everything else. A beat offered in this cycle is
      // dropped, because the accumulator is cleared regardless of the handshake.
      state_d     = IDLE;
      acc_d       = '0;
      remaining_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            acc_d = '0;
            if (len_i != '0) begin
              remaining_d = len_i;
              state_d     = ACCUM;
            end else begin
              // A zero-length vector goes straight to presenting a result of 0.
              state_d = DONE;
            end
          end
        end
        ACCUM: begin
          // prod_ready_o is high for the whole of ACCUM, so prod_valid_i on
          // its own marks an accepted beat.
          if (prod_valid_i) begin
            acc_d       = acc_q + prod_ext;
            remaining_d = remaining_q - LenWidth'(1);
            if (remaining_q == LenWidth'(1)) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (result_ready_i) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      remaining_q <= remaining_d;
    end
  end

  assign prod_ready_o   = (state_q == ACCUM);
  assign result_valid_o = (state_q == DONE);
  assign busy_o         = (state_q == ACCUM) || (state_q == DONE);
  // The result bus is driven only while it is valid. It stays stable through
  // DONE because acc_q does not change in that state.
  assign result_o       = (state_q == DONE) ? acc_q : '0;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_dot_product_accumulator
//
// Directed and randomized bench for dot_product_accumulator. The expected
// result of every vector is the plain arithmetic sum of the products the
// bench offered. Each comparison is an immediate assertion.
// ---------------------------------------------------------------------------
module tb_dot_product_accumulator;

  localparam int Width    = 8;
  localparam int LenWidth = 8;
  localparam int AccWidth = 2*Width+LenWidth;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                start_i;
  logic [LenWidth-1:0] len_i;
  logic                abort_i;
  logic                prod_valid_i;
  logic                prod_ready_o;
  logic [2*Width-1:0]  prod_i;
  logic                result_valid_o;
  logic                result_ready_i;
  logic [AccWidth-1:0] result_o;
  logic                busy_o;

  int checks   = 0;
  int failures = 0;

  dot_product_accumulator #(
    .Width    (Width),
    .LenWidth (LenWidth)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .len_i          (len_i),
    .abort_i        (abort_i),
    .prod_valid_i   (prod_valid_i),
    .prod_ready_o   (prod_ready_o),
    .prod_i         (prod_i),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_o       (result_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Step to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_vec(input int len);
    check("idle_busy", busy_o, 0);
    check("idle_ready", prod_ready_o, 0);
    start_i = 1'b1;
    len_i   = LenWidth'(len);
    tick();
    start_i = 1'b0;
    len_i   = '0;
  endtask

  // Offer one product after some idle cycles. During the idle cycles the bench
  // also raises start_i with len_i=0, which the block must ignore while it
  // is accumulating.
  task automatic beat(input logic [15:0] p, input int gaps);
    for (int g = 0; g < gaps; g++) begin
      prod_valid_i = 1'b0;
      start_i      = 1'b1;
      len_i        = '0;
      check("gap_ready", prod_ready_o, 1);
      check("gap_valid", result_valid_o, 0);
      tick();
    end
    start_i      = 1'b0;
    prod_valid_i = 1'b1;
    prod_i       = p;
    check("beat_ready", prod_ready_o, 1);
    check("beat_busy", busy_o, 1);
    check("beat_nores", result_valid_o, 0);
    tick();
    prod_valid_i = 1'b0;
    prod_i       = '0;
  endtask

  task automatic expect_result(input string tag, input logic [63:0] exp);
    check({tag, "_valid"}, result_valid_o, 1);
    check({tag, "_value"}, result_o, exp);
    check({tag, "_ready0"}, prod_ready_o, 0);
    check({tag, "_busy"}, busy_o, 1);
  endtask

  task automatic handshake();
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
    check("post_hs_valid", result_valid_o, 0);
    check("post_hs_busy", busy_o, 0);
  endtask

  logic [63:0] exp_sum;
  logic [63:0] held;
  logic [15:0] p;
  int          n;

  initial begin
    rst_i = 1'b1; start_i = 1'b0; len_i = '0; abort_i = 1'b0;
    prod_valid_i = 1'b0; prod_i = '0; result_ready_i = 1'b0;
    #12;
    check("rst_valid", result_valid_o, 0);
    check("rst_ready", prod_ready_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_result", result_o, 0);
    rst_i = 1'b0;
    tick();

    // Reset asserted in the middle of an accumulation.
    start_vec(4);
    beat(16'd100, 0);
    beat(16'd200, 0);
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_ready", prod_ready_o, 0);
    check("async_rst_busy", busy_o, 0);
    check("async_rst_valid", result_valid_o, 0);
    check("async_rst_result", result_o, 0);
    #2 rst_i = 1'b0;
    tick();
    check("after_rst_busy", busy_o, 0);
    start_vec(1);
    beat(16'd9, 0);
    expect_result("after_rst", 9);
    handshake();

    // Three products; the result appears the cycle after the third accepted beat.
    start_vec(3);
    beat(16'd6, 0);
    beat(16'd20, 0);
    beat(16'd65025, 0);
    expect_result("len3", 65051);
    handshake();

    // Zero length: the result is 0 the cycle after start, and no beat is ever accepted.
    start_vec(0);
    expect_result("len0", 0);
    handshake();

    // Maximum length with maximum products and random gaps.
    start_vec(255);
    exp_sum = 0;
    for (int i = 0; i < 255; i++) begin
      beat(16'd65025, int'($urandom_range(0, 2)));
      exp_sum += 65025;
    end
    expect_result("len255", exp_sum);
    handshake();

    // Back-pressure in DONE: the result stays stable and start_i is ignored.
    start_vec(2);
    beat(16'd1234, 1);
    beat(16'd4321, 0);
    held = 64'd5555;
    for (int c = 0; c < 5; c++) begin
      start_i = 1'b1;
      len_i   = 8'd5;
      expect_result("stall", held);
      tick();
    end
    start_i = 1'b0;
    len_i   = '0;
    expect_result("stall_end", held);
    handshake();

    // Abort after 2 of 4 beats, with a beat offered in the abort cycle.
    start_vec(4);
    beat(16'd50, 0);
    beat(16'd60, 0);
    abort_i = 1'b1;
    prod_valid_i = 1'b1;
    prod_i = 16'd70;
    tick();
    abort_i = 1'b0;
    prod_valid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("abort_valid", result_valid_o, 0);
      check("abort_busy", busy_o, 0);
      check("abort_ready", prod_ready_o, 0);
      tick();
    end
    start_vec(1);
    beat(16'd9, 0);
    expect_result("after_abort", 9);
    handshake();

    // Abort while a result is being held.
    start_vec(0);
    expect_result("pre_abort_done", 0);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_done_valid", result_valid_o, 0);
    check("abort_done_busy", busy_o, 0);

    // Random vectors.
    for (int v = 0; v < 8; v++) begin
      n = int'($urandom_range(1, 12));
      start_vec(n);
      exp_sum = 0;
      for (int i = 0; i < n; i++) begin
        p = 16'($urandom);
        exp_sum += 64'(p);
        beat(p, int'($urandom_range(0, 3)));
      end
      expect_result("rand", exp_sum);
      handshake();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
